// File: rtl/min_res_datapath_pkg.sv
// Shared encodings for the minimum-resource datapath.
//  MUL_SEL_* : multiplier operand select (reg_b*2, reg_b*5, reg_c*add_r)
//  ADD_SEL_* : adder select (both active codes compute reg_a + mul_r)
//  last_op_e : which functional unit produced the most recent result
package min_res_pkg;

  localparam logic [1:0] MUL_SEL_NOP = 2'b00;
  localparam logic [1:0] MUL_SEL_B2  = 2'b01;
  localparam logic [1:0] MUL_SEL_B5  = 2'b10;
  localparam logic [1:0] MUL_SEL_CS  = 2'b11;

  localparam logic [1:0] ADD_SEL_NOP = 2'b00;
  localparam logic [1:0] ADD_SEL_A1  = 2'b01;
  localparam logic [1:0] ADD_SEL_A2  = 2'b10;

  typedef enum logic {
    LAST_OP_ADD = 1'b0,
    LAST_OP_MUL = 1'b1
  } last_op_e;

  // Code 11 is left unassigned for the adder and behaves as a no-op.
  function automatic logic add_sel_active(input logic [1:0] sel);
    return (sel == ADD_SEL_A1) || (sel == ADD_SEL_A2);
  endfunction

endpackage

// File: rtl/min_res_datapath_ram.sv
// Word RAM: one synchronous write port, NUM_RD combinational read ports.
//  clk    : write clock
//  we     : write enable
//  waddr  : write index
//  wdata  : write word
//  raddr  : packed array of read indices, one per read port
//  rdata  : packed array of read words, one per read port
// Contents are not reset. A read at the write index returns the old word
// during the write cycle (read-before-write).
module mr_word_ram
  import min_res_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int NUM_RD = 1,
  parameter int AW     = 10
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [AW-1:0]                  waddr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [NUM_RD-1:0][AW-1:0]      raddr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    assign rdata[g] = mem[raddr[g]];
  end

endmodule

// File: rtl/min_res_datapath.sv
// Minimum-resource datapath: one multiplier, one adder, three word RAMs.
// Captures a[] then b[] from a host word stream, then, under control of an
// external loop controller, computes pass 1 c=a+2b and pass 2 c=c*(a+5b).
// Once the controller signals done, a read port returns c[] to the host.
//  clk, rst            : clock, synchronous active-high reset
//  we, data_in, n      : host input stream and vector length
//  store_ab            : capture phase (overrides store/load strobes)
//  load_{a,b,c}_en     : load operand register from memory at index_loop
//  store_c_en          : write last result to c_mem[index_loop]
//  mul_en/mul_sel      : multiplier strobe and operand select
//  add_en/add_sel      : adder strobe and select
//  index_loop          : element index for loads/stores
//  done, rd_en, rd_addr: host read request (accepted only when done)
//  rd_data, rd_valid   : read word and its one-cycle valid pulse
//  ovf_err             : sticky, a capture write fell beyond DEPTH
module min_res_datapath
  import min_res_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] data_in,
  input  logic [31:0]       n,
  input  logic              store_ab,
  input  logic              load_a_en,
  input  logic              load_b_en,
  input  logic              load_c_en,
  input  logic              store_c_en,
  input  logic              mul_en,
  input  logic              add_en,
  input  logic [1:0]        mul_sel,
  input  logic [1:0]        add_sel,
  input  logic [9:0]        index_loop,
  input  logic              done,
  input  logic              rd_en,
  input  logic [9:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              ovf_err
);

  localparam int AW = 10;

  logic [DATA_W-1:0] reg_a, reg_b, reg_c, mul_r, add_r;
  logic [32:0]       wr_cnt;
  last_op_e          last_op;

  // ---------------- capture addressing ----------------
  // 33-bit arithmetic so 2n never wraps for any 32-bit n.
  logic [32:0] n_ext, n_x2, cap_idx;
  logic        cap_fire, cap_is_a, cap_in_rng;

  assign n_ext      = {1'b0, n};
  assign n_x2       = {n, 1'b0};
  assign cap_fire   = store_ab & we & (wr_cnt < n_x2);
  assign cap_is_a   = wr_cnt < n_ext;
  assign cap_idx    = cap_is_a ? wr_cnt : (wr_cnt - n_ext);
  assign cap_in_rng = cap_idx < 33'(DEPTH);

  // ---------------- memories ----------------
  logic [0:0][DATA_W-1:0] a_rd, b_rd;
  logic [1:0][DATA_W-1:0] c_rd;   // [0] datapath at index_loop, [1] host at rd_addr
  logic [0:0][AW-1:0]     idx_vec;
  logic [1:0][AW-1:0]     c_raddr;
  logic                   a_we, b_we, c_we;
  logic [DATA_W-1:0]      c_wdata;

  assign idx_vec  = index_loop;
  assign c_raddr  = {rd_addr, index_loop};
  assign a_we     = cap_fire & cap_in_rng & cap_is_a;
  assign b_we     = cap_fire & cap_in_rng & ~cap_is_a;
  assign c_we     = store_c_en & ~store_ab & (32'(index_loop) < DEPTH);
  assign c_wdata  = (last_op == LAST_OP_MUL) ? mul_r : add_r;

  mr_word_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(1), .AW(AW)) u_a_mem (
    .clk(clk), .we(a_we), .waddr(cap_idx[AW-1:0]), .wdata(data_in),
    .raddr(idx_vec), .rdata(a_rd)
  );

  mr_word_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(1), .AW(AW)) u_b_mem (
    .clk(clk), .we(b_we), .waddr(cap_idx[AW-1:0]), .wdata(data_in),
    .raddr(idx_vec), .rdata(b_rd)
  );

  mr_word_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(2), .AW(AW)) u_c_mem (
    .clk(clk), .we(c_we), .waddr(index_loop), .wdata(c_wdata),
    .raddr(c_raddr), .rdata(c_rd)
  );

  // ---------------- shared multiplier ----------------
  // Single multiplier; the constant factors 2 and 5 are muxed onto its
  // second operand rather than built as separate shift-add paths.
  logic [DATA_W-1:0] mul_x, mul_y, mul_p;
  logic              mul_do, add_do;

  assign mul_x  = (mul_sel == MUL_SEL_CS) ? reg_c : reg_b;
  assign mul_y  = (mul_sel == MUL_SEL_CS) ? add_r :
                  (mul_sel == MUL_SEL_B2) ? DATA_W'(2) : DATA_W'(5);
  assign mul_p  = mul_x * mul_y;
  assign mul_do = mul_en & (mul_sel != MUL_SEL_NOP);
  assign add_do = add_en & add_sel_active(add_sel);

  // ---------------- state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a    <= '0;
      reg_b    <= '0;
      reg_c    <= '0;
      mul_r    <= '0;
      add_r    <= '0;
      wr_cnt   <= '0;
      last_op  <= LAST_OP_ADD;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      if (load_a_en & ~store_ab) reg_a <= a_rd[0];
      if (load_b_en & ~store_ab) reg_b <= b_rd[0];
      if (load_c_en & ~store_ab) reg_c <= c_rd[0];

      // Both units read pre-edge operands; MUL wins last_op on a tie.
      if (mul_do) mul_r <= mul_p;
      if (add_do) add_r <= reg_a + mul_r;
      if (mul_do)      last_op <= LAST_OP_MUL;
      else if (add_do) last_op <= LAST_OP_ADD;

      if (cap_fire) begin
        wr_cnt <= wr_cnt + 33'd1;
        if (!cap_in_rng) ovf_err <= 1'b1;
      end

      rd_valid <= rd_en & done;
      if (rd_en & done) rd_data <= c_rd[1];
    end
  end

endmodule

// File: tb/tb_min_res_datapath.sv
module tb_min_res_datapath;

  logic        clk = 1'b0;
  logic        rst, we, store_ab, load_a_en, load_b_en, load_c_en, store_c_en;
  logic        mul_en, add_en, done, rd_en;
  logic [31:0] data_in, n;
  logic [1:0]  mul_sel, add_sel;
  logic [9:0]  index_loop, rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid, ovf_err;

  always #5 clk = ~clk;

  min_res_datapath #(.DATA_W(32), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .we(we), .data_in(data_in), .n(n),
    .store_ab(store_ab), .load_a_en(load_a_en), .load_b_en(load_b_en),
    .load_c_en(load_c_en), .store_c_en(store_c_en), .mul_en(mul_en),
    .add_en(add_en), .mul_sel(mul_sel), .add_sel(add_sel),
    .index_loop(index_loop), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .ovf_err(ovf_err)
  );

  typedef struct {
    int              nn;
    logic [1:0][31:0] a, b, p1, p2;
  } vec_t;

  vec_t tbl [4];
  int   n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    we = 0; store_ab = 0; load_a_en = 0; load_b_en = 0; load_c_en = 0;
    store_c_en = 0; mul_en = 0; add_en = 0; mul_sel = 0; add_sel = 0;
    rd_en = 0;
  endtask

  task automatic do_reset();
    idle(); done = 0; rst = 1; tick(); rst = 0;
  endtask

  // Stream cnt words; with poke, also assert store/load strobes that must be ignored.
  task automatic capture(input int cnt, input logic [31:0] w [8], input bit poke);
    for (int i = 0; i < cnt; i++) begin
      idle(); store_ab = 1; we = 1; data_in = w[i];
      if (poke) begin store_c_en = 1; load_a_en = 1; index_loop = 0; end
      tick();
    end
    idle();
  endtask

  task automatic pass1_elem(input int i);
    idle(); index_loop = 10'(i); load_a_en = 1; load_b_en = 1; tick();
    idle(); mul_en = 1; mul_sel = 2'b01; tick();
    idle(); add_en = 1; add_sel = 2'b01; tick();
    idle(); store_c_en = 1; tick();
    idle();
  endtask

  task automatic pass2_elem(input int i);
    idle(); index_loop = 10'(i); load_a_en = 1; load_b_en = 1; load_c_en = 1; tick();
    idle(); mul_en = 1; mul_sel = 2'b10; tick();
    idle(); add_en = 1; add_sel = 2'b10; tick();
    idle(); mul_en = 1; mul_sel = 2'b11; tick();
    idle(); store_c_en = 1; tick();
    idle();
  endtask

  task automatic read_chk(input string name, input int addr, input logic [31:0] exp);
    idle(); done = 1; rd_en = 1; rd_addr = 10'(addr); tick();
    check({name, "_valid"}, 32'(rd_valid), 32'd1);
    check(name, rd_data, exp);
    rd_en = 0; done = 0;
  endtask

  initial begin
    logic [31:0] w [8];
    idle(); done = 0; rst = 1; n = 0; data_in = 0; index_loop = 0; rd_addr = 0;

    tbl[0] = '{nn: 2, a: {32'd4, 32'd3},  b: {32'd2, 32'd1}, p1: {32'd8, 32'd5},  p2: {32'd112, 32'd40}};
    tbl[1] = '{nn: 1, a: {32'd0, 32'hFFFF_FFFF}, b: {32'd0, 32'd1}, p1: {32'd0, 32'd1}, p2: {32'd0, 32'd4}};
    tbl[2] = '{nn: 1, a: {32'd0, 32'd2},  b: {32'd0, 32'd3}, p1: {32'd0, 32'd8},  p2: {32'd0, 32'd136}};
    tbl[3] = '{nn: 2, a: {32'd0, 32'd10}, b: {32'd7, 32'd0}, p1: {32'd14, 32'd10}, p2: {32'd490, 32'd100}};

    tick(); tick();
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_ovf", 32'(ovf_err), 32'd0);
    rst = 0;

    // ---- table-driven full runs ----
    for (int v = 0; v < 4; v++) begin
      do_reset();
      n = 32'(tbl[v].nn);
      w = '{default: 32'd0};
      for (int i = 0; i < tbl[v].nn; i++) begin
        w[i] = tbl[v].a[i];
        w[tbl[v].nn + i] = tbl[v].b[i];
      end
      capture(2 * tbl[v].nn, w, v > 0);
      if (v > 0) read_chk($sformatf("v%0d_storeab_prio", v), 0, tbl[v-1].p2[0]);
      for (int i = 0; i < tbl[v].nn; i++) pass1_elem(i);
      for (int i = 0; i < tbl[v].nn; i++) read_chk($sformatf("v%0d_p1_c%0d", v, i), i, tbl[v].p1[i]);
      for (int i = 0; i < tbl[v].nn; i++) pass2_elem(i);
      for (int i = 0; i < tbl[v].nn; i++) read_chk($sformatf("v%0d_p2_c%0d", v, i), i, tbl[v].p2[i]);
    end

    // ---- extra word beyond 2n is ignored ----
    do_reset();
    n = 2;
    w = '{default: 32'd0};
    w[0] = 3; w[1] = 4; w[2] = 1; w[3] = 2; w[4] = 9;
    capture(5, w, 1'b0);
    pass1_elem(0); pass1_elem(1);
    read_chk("extra_c1", 1, 32'd8);
    read_chk("extra_c0", 0, 32'd5);
    check("extra_ovf", 32'(ovf_err), 32'd0);

    // ---- read before done, then a single-cycle valid pulse ----
    idle(); done = 0; rd_en = 1; rd_addr = 1; tick();
    check("nodone_valid", 32'(rd_valid), 32'd0);
    check("nodone_hold", rd_data, 32'd5);
    done = 1; rd_en = 1; rd_addr = 1; tick();
    check("pulse_valid_t1", 32'(rd_valid), 32'd1);
    check("pulse_data_t1", rd_data, 32'd8);
    rd_en = 0; tick();
    check("pulse_valid_t2", 32'(rd_valid), 32'd0);
    done = 0;

    // ---- mul_sel=00 holds mul_r and last_op ----
    do_reset();
    n = 1;
    w = '{default: 32'd0};
    w[0] = 2; w[1] = 3;
    capture(2, w, 1'b0);
    pass1_elem(0);                              // mul_r=6, add_r=8, last=ADD
    idle(); mul_en = 1; mul_sel = 2'b00; tick();
    idle(); index_loop = 1; store_c_en = 1; tick();
    read_chk("nop_store_addr", 1, 32'd8);
    idle(); add_en = 1; add_sel = 2'b01; tick(); // 2 + 6 only if mul_r held
    idle(); mul_en = 1; mul_sel = 2'b00; tick();
    idle(); index_loop = 2; store_c_en = 1; tick();
    read_chk("nop_mulr_held", 2, 32'd8);

    // ---- capture index beyond DEPTH sets sticky ovf_err ----
    do_reset();
    n = 1025;
    for (int i = 0; i < 1024; i++) begin
      idle(); store_ab = 1; we = 1; data_in = 32'(i); tick();
    end
    idle();
    check("ovf_before", 32'(ovf_err), 32'd0);
    store_ab = 1; we = 1; data_in = 32'hDEAD; tick();
    idle(); tick();
    check("ovf_after", 32'(ovf_err), 32'd1);
    read_chk("ovf_rd_c0", 0, 32'd8);

    // ---- reset mid pass 2, then rerun ----
    idle(); index_loop = 0; load_a_en = 1; load_b_en = 1; load_c_en = 1; tick();
    idle(); mul_en = 1; mul_sel = 2'b10; tick();
    idle(); done = 1; rd_en = 1; rd_addr = 0; rst = 1; tick();
    check("midrst_rd_data", rd_data, 32'd0);
    check("midrst_rd_valid", 32'(rd_valid), 32'd0);
    check("midrst_ovf", 32'(ovf_err), 32'd0);
    rst = 0; idle(); done = 0;
    n = 1;
    w = '{default: 32'd0};
    w[0] = 2; w[1] = 3;
    capture(2, w, 1'b0);
    pass1_elem(0);
    pass2_elem(0);
    read_chk("rerun_c0", 0, 32'd136);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
